branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 4, giving log2 of the table depth (16 entries).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port if_pc  input  32  fetch-stage PC to predict.
REQ-005 The block SHALL have port pred_taken  output  1  predicted branch outcome for if_pc.
REQ-006 The block SHALL have port pred_target  output  32  predicted next PC for if_pc.
REQ-007 The block SHALL have port ex_valid  input  1  execute-stage instruction valid.
REQ-008 The block SHALL have port ex_branch  input  1  execute-stage instruction is a conditional branch (Branch).
REQ-009 The block SHALL have port ex_cnd  input  1  resolved outcome (Cnd) from the branch unit.
REQ-010 The block SHALL have port ex_pc  input  32  execute-stage instruction PC.
REQ-011 The block SHALL have port ex_target  input  32  resolved branch target.
REQ-012 The block SHALL have port ex_pred_taken  input  1  prediction carried down the pipeline with the instruction.
REQ-013 The block SHALL have port ex_pred_target  input  32  predicted target carried down the pipeline.
REQ-014 The block SHALL have port mispredict  output  1  flush request to the front end.
REQ-015 The block SHALL have port redirect_pc  output  32  correct next PC, valid when mispredict=1.
REQ-016 The block SHALL have port br_count  output  32  number of resolved branches.
REQ-017 The block SHALL have port mp_count  output  32  number of mispredicts.

Function
REQ-018 Each entry SHALL hold: valid (1), tag (if_pc[31:IDX_BITS+2]), target (32), 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-019 Index SHALL be pc[IDX_BITS+1:2]; hit SHALL be valid && tag match.
REQ-020 pred_taken SHALL be hit && counter[1], combinational from current state (zero latency).
REQ-021 pred_target SHALL be the entry target when pred_taken=1, else if_pc+4 (mod 2^32).
REQ-022 Update SHALL occur at the clock edge when ex_valid && ex_branch.
REQ-023 On update hit, the counter SHALL saturate: +1 if ex_cnd (max 11), -1 otherwise (min 00); the target SHALL be written with ex_target when ex_cnd=1.
REQ-024 On update miss, the entry SHALL be allocated: valid=1, tag, target=ex_target, counter = ex_cnd ? 10 : 01.
REQ-025 When ex_valid && !ex_branch && ex_pred_taken (alias), the entry at the ex_pc index SHALL be invalidated if its tag matches.
REQ-026 mispredict SHALL be combinational: ex_valid && ((ex_branch && (ex_cnd != ex_pred_taken || (ex_cnd && ex_pred_target != ex_target))) || (!ex_branch && ex_pred_taken)).
REQ-027 redirect_pc SHALL be ex_target when ex_branch && ex_cnd, else ex_pc+4.
REQ-028 When a fetch and an update target the same index in the same cycle, the prediction SHALL use the pre-update state (no bypass).
REQ-029 br_count SHALL increment on each update; mp_count SHALL increment on each mispredict=1 cycle; both SHALL wrap modulo 2^32.
REQ-030 ex_cnd SHALL be ignored when ex_branch=0.

Reset
REQ-031 While rst=1 at the clock edge, all valid bits SHALL clear, all counters SHALL become 01, and br_count and mp_count SHALL become 0.
REQ-032 rst SHALL override a coincident update or invalidate.
REQ-033 After reset, pred_taken SHALL be 0 and pred_target SHALL be if_pc+4.
REQ-034 mispredict SHALL still follow its inputs during reset; the pipeline gates it.

Structure
REQ-035 The counter encodings and the IDX_BITS default SHALL live in a shared package/header used by the fetch and execute stages.
REQ-036 The 2-bit saturating counter update SHALL be one sub-module, sat_counter2; the table and counters SHALL be in branch_predictor.

Verification
REQ-037 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-038 Resolve a taken branch at ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80, next cycle if_pc=0x100 predicts taken to 0x80.
REQ-039 Four consecutive not-taken resolutions at 0x100 after allocate -> counter 10→01→00→00 (saturates), pred_taken=0 from the second.
REQ-040 Alias test: ex_pc=0x140 (same index, different tag) taken -> replaces the entry; 0x100 then misses.
REQ-041 Non-branch at 0x100 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104, entry invalidated.
REQ-042 Preset mp_count=0xFFFFFFFF via a forced mispredict sequence -> wraps to 0; rst mid-update -> table cleared, no allocation.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side predictor and execute-side resolution.
package branch_predictor_pkg;
  localparam int IDX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-state: step toward taken or not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = cnt;
    if (up) begin
      if (cnt != 2'(ST)) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'(SNT)) nxt = cnt - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency predict, resolve/update at execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_cnd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0][TAG_W-1:0] tag;
  logic [DEPTH-1:0][31:0]      tgt;
  logic [DEPTH-1:0][1:0]       ctr, ctr_nxt;
  logic [31:0]                 br_q, mp_q;

  logic [IDX_BITS-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic                f_hit, e_hit, upd, inv;
  logic                unused;

  assign f_idx  = if_pc[IDX_BITS+1:2];
  assign f_tag  = if_pc[31:IDX_BITS+2];
  assign e_idx  = ex_pc[IDX_BITS+1:2];
  assign e_tag  = ex_pc[31:IDX_BITS+2];
  assign unused = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch reads only registered state, so a same-cycle update is not bypassed.
  assign f_hit       = vld[f_idx] && (tag[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr[f_idx][1];
  assign pred_target = pred_taken ? tgt[f_idx] : if_pc + 32'd4;

  assign e_hit = vld[e_idx] && (tag[e_idx] == e_tag);
  assign upd   = ex_valid && ex_branch;
  assign inv   = ex_valid && !ex_branch && ex_pred_taken;

  assign mispredict  = ex_valid &&
                       ((ex_branch && (ex_cnd != ex_pred_taken ||
                                       (ex_cnd && ex_pred_target != ex_target))) ||
                        (!ex_branch && ex_pred_taken));
  assign redirect_pc = (ex_branch && ex_cnd) ? ex_target : ex_pc + 32'd4;
  assign br_count    = br_q;
  assign mp_count    = mp_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    sat_counter2 u_ctr (.cnt(ctr[g]), .up(ex_cnd), .nxt(ctr_nxt[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= '0;
      ctr  <= {DEPTH{2'(WNT)}};
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (upd) begin
        br_q <= br_q + 32'd1;
        if (e_hit) begin
          ctr[e_idx] <= ctr_nxt[e_idx];
          if (ex_cnd) tgt[e_idx] <= ex_target;
        end else begin
          vld[e_idx] <= 1'b1;
          tag[e_idx] <= e_tag;
          tgt[e_idx] <= ex_target;
          ctr[e_idx] <= ex_cnd ? 2'(WT) : 2'(WNT);
        end
      end else if (inv && e_hit) begin
        vld[e_idx] <= 1'b0;
      end
      if (mispredict) mp_q <= mp_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver queues hand-computed expectations, monitor checks at negedge.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        ex_valid, ex_branch, ex_cnd, ex_pred_taken;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, br_count, mp_count;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_cnd(ex_cnd),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] br;
    logic [31:0] mpc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pred_taken",  32'(pred_taken),  32'(e.pt));
      chk(e.nm, "pred_target", pred_target,      e.ptg);
      chk(e.nm, "mispredict",  32'(mispredict),  32'(e.mp));
      chk(e.nm, "redirect_pc", redirect_pc,      e.rd);
      chk(e.nm, "br_count",    br_count,         e.br);
      chk(e.nm, "mp_count",    mp_count,         e.mpc);
    end
  end

  task automatic cyc(input string nm, input logic [31:0] pc,
                     input logic v, input logic b, input logic c,
                     input logic [31:0] epc, input logic [31:0] etg,
                     input logic ept, input logic [31:0] eptg,
                     input logic xpt, input logic [31:0] xptg,
                     input logic xmp, input logic [31:0] xrd,
                     input logic [31:0] xbr, input logic [31:0] xmpc);
    exp_t e;
    if_pc = pc; ex_valid = v; ex_branch = b; ex_cnd = c;
    ex_pc = epc; ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
    e = '{nm: nm, pt: xpt, ptg: xptg, mp: xmp, rd: xrd, br: xbr, mpc: xmpc};
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] pc,
                      input logic xpt, input logic [31:0] xptg,
                      input logic [31:0] xbr, input logic [31:0] xmpc);
    cyc(nm, pc, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, xpt, xptg, 0, 32'h4, xbr, xmpc);
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h100; ex_valid = 0; ex_branch = 0; ex_cnd = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle("reset", 32'h100, 0, 32'h104, 0, 0);
    // allocate taken; prediction in the same cycle sees pre-update state
    cyc("alloc", 32'h100, 1,1,1, 32'h100, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0, 0);
    idle("hit_taken", 32'h100, 1, 32'h80, 1, 1);
    cyc("nt1", 32'h100, 1,1,0, 32'h100, 32'h0, 1, 32'h80,  1, 32'h80,  1, 32'h104, 1, 1);
    cyc("nt2", 32'h100, 1,1,0, 32'h100, 32'h0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 2, 2);
    cyc("nt3", 32'h100, 1,1,0, 32'h100, 32'h0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 3, 2);
    cyc("nt4", 32'h100, 1,1,0, 32'h100, 32'h0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 4, 2);
    // from saturated 00 one taken step only reaches 01
    cyc("t_from0", 32'h100, 1,1,1, 32'h100, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 5, 2);
    idle("still_nt", 32'h100, 0, 32'h104, 6, 3);
    cyc("t_to10", 32'h100, 1,1,1, 32'h100, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 6, 3);
    cyc("t_to11", 32'h100, 1,1,1, 32'h100, 32'h80, 1, 32'h80,  1, 32'h80,  0, 32'h80, 7, 4);
    cyc("tgt_mis", 32'h100, 1,1,1, 32'h100, 32'h90, 1, 32'h80, 1, 32'h80,  1, 32'h90, 8, 4);
    cyc("nt_from11", 32'h100, 1,1,0, 32'h100, 32'h0, 1, 32'h90, 1, 32'h90, 1, 32'h104, 9, 5);
    idle("sat_hi", 32'h100, 1, 32'h90, 10, 6);
    // alias: same index, different tag
    cyc("alias", 32'h140, 1,1,1, 32'h140, 32'h200, 0, 32'h144, 0, 32'h144, 1, 32'h200, 10, 6);
    idle("old_miss", 32'h100, 0, 32'h104, 11, 7);
    idle("new_hit", 32'h140, 1, 32'h200, 11, 7);
    cyc("inv_nomatch", 32'h140, 1,0,1, 32'h100, 32'h300, 1, 32'h0, 1, 32'h200, 1, 32'h104, 11, 7);
    idle("kept", 32'h140, 1, 32'h200, 11, 8);
    cyc("inv_match", 32'h140, 1,0,1, 32'h140, 32'h300, 1, 32'h0, 1, 32'h200, 1, 32'h144, 11, 8);
    idle("invalidated", 32'h140, 0, 32'h144, 11, 9);
    cyc("nb_cnd_ign", 32'h140, 1,0,1, 32'h140, 32'h200, 0, 32'h0, 0, 32'h144, 0, 32'h144, 11, 9);
    idle("no_alloc", 32'h140, 0, 32'h144, 11, 9);
    cyc("ex_invalid", 32'h140, 0,1,1, 32'h140, 32'h200, 0, 32'h0, 0, 32'h144, 0, 32'h200, 11, 9);
    idle("no_upd", 32'h140, 0, 32'h144, 11, 9);

    force dut.mp_q = 32'hFFFF_FFFF;
    #1 release dut.mp_q;
    cyc("mp_wrap", 32'h100, 1,0,0, 32'h180, 32'h0, 1, 32'h0, 0, 32'h104, 1, 32'h184, 11, 32'hFFFF_FFFF);
    idle("wrapped", 32'h100, 0, 32'h104, 11, 0);

    cyc("alloc2", 32'h104, 1,1,1, 32'h104, 32'h400, 0, 32'h108, 0, 32'h108, 1, 32'h400, 11, 0);
    idle("hit2", 32'h104, 1, 32'h400, 12, 1);
    rst = 1'b1;
    cyc("rst_upd", 32'h104, 1,1,1, 32'h108, 32'h500, 0, 32'h10c, 1, 32'h400, 1, 32'h500, 12, 1);
    rst = 1'b0;
    idle("cleared", 32'h104, 0, 32'h108, 0, 0);
    idle("rst_no_alloc", 32'h108, 0, 32'h10c, 0, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: test did not complete expected done");
      $fatal(1);
    end
  end
endmodule
